// File: rtl/fll_seq_pkg.sv
// fll_seq_pkg: shared types and FLL config-register-1 layout for the reconfiguration sequencer.
//   state_e     sequencer FSM states
//   status_e    completion status codes reported on done_status_o
//   cfg1_merge  builds the new CFG1 word from the read-back value and the new mult/div
package fll_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_REL,
        ST_WR_REQ,
        ST_WR_REL,
        ST_LOCK_WAIT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        STAT_OK      = 2'b00,
        STAT_LOCK_TO = 2'b01,
        STAT_ACK_TO  = 2'b10
    } status_e;

    localparam logic [1:0] FLL_CFG1_ADDR = 2'b01;

    localparam int MULT_LSB = 0;
    localparam int MULT_W   = 16;
    localparam int DCO_LSB  = 16;
    localparam int DCO_W    = 10;
    localparam int DIV_LSB  = 26;
    localparam int DIV_W    = 4;
    localparam int MODE_LSB = 30;
    localparam int MODE_W   = 2;

    // Keeps MODE and DCO from the read-back word, replaces DIV and MULT.
    function automatic logic [31:0] cfg1_merge(
        input logic [31:0]       rd,
        input logic [DIV_W-1:0]  div,
        input logic [MULT_W-1:0] mult
    );
        logic [31:0] w;
        w = '0;
        w[MODE_LSB +: MODE_W] = rd[MODE_LSB +: MODE_W];
        w[DCO_LSB  +: DCO_W]  = rd[DCO_LSB  +: DCO_W];
        w[DIV_LSB  +: DIV_W]  = div;
        w[MULT_LSB +: MULT_W] = mult;
        return w;
    endfunction

endpackage

// File: rtl/fll_sync_2ff.sv
// fll_sync_2ff: two-flop synchronizer for a single asynchronous level, reset to 0.
//   clk_i  destination clock
//   rst_ni asynchronous active-low reset
//   d_i    asynchronous input
//   q_o    synchronized output (2-cycle latency)
module fll_sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/fll_reconfig_seq.sv
// fll_reconfig_seq: retargets an FLL by read-modify-write of CFG1 over the 4-phase
// req/ack port, then waits for a stable synchronized lock.
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   req_valid_i/req_ready_o          reconfiguration request handshake
//   req_mult_i, req_div_i            new multiplier / divider
//   done_valid_o, done_status_o      completion pulse and held status (00 OK, 01 LOCK_TO, 10 ACK_TO)
//   busy_o                           sequencer not idle
//   fll_req_o/wrn_o/addr_o/wdata_o   FLL register port requests
//   fll_ack_i, fll_rdata_i           FLL acknowledge (async) and read data
//   fll_lock_i, lock_o               FLL lock (async) and its synchronized copy
module fll_reconfig_seq
    import fll_seq_pkg::*;
#(
    parameter int ACK_TIMEOUT  = 256,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [15:0] req_mult_i,
    input  logic [3:0]  req_div_i,
    output logic        done_valid_o,
    output logic [1:0]  done_status_o,
    output logic        busy_o,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_addr_o,
    output logic [31:0] fll_wdata_o,
    input  logic        fll_ack_i,
    input  logic [31:0] fll_rdata_i,
    input  logic        fll_lock_i,
    output logic        lock_o
);

    localparam int AW = $clog2(ACK_TIMEOUT) + 1;
    localparam int LW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int SW = $clog2(LOCK_STABLE) + 1;
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
    localparam logic [LW-1:0] WAIT_LAST = LW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);

    logic ack_s;
    logic lock_s;

    state_e         state_q,    state_d;
    status_e        status_q,   status_d;
    logic [15:0]    mult_q,     mult_d;
    logic [3:0]     div_q,      div_d;
    logic [31:0]    rdata_q,    rdata_d;
    logic [AW-1:0]  ack_cnt_q,  ack_cnt_d;
    logic [LW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [SW-1:0]  stab_cnt_q, stab_cnt_d;
    logic           ack_to;

    fll_sync_2ff u_sync_ack (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (fll_ack_i),
        .q_o    (ack_s)
    );

    fll_sync_2ff u_sync_lock (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (fll_lock_i),
        .q_o    (lock_s)
    );

    assign ack_to = ack_cnt_q == ACK_LAST;

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        mult_d   = mult_q;
        div_d    = div_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    state_d = ST_RD_REQ;
                    mult_d  = req_mult_i;
                    div_d   = req_div_i;
                end
            end
            ST_RD_REQ: begin
                if (ack_s) begin
                    state_d = ST_RD_REL;
                    rdata_d = fll_rdata_i;
                end else if (ack_to) begin
                    state_d  = ST_DONE;
                    status_d = STAT_ACK_TO;
                end
            end
            ST_RD_REL: begin
                if (!ack_s) begin
                    state_d = ST_WR_REQ;
                end else if (ack_to) begin
                    state_d  = ST_DONE;
                    status_d = STAT_ACK_TO;
                end
            end
            ST_WR_REQ: begin
                if (ack_s) begin
                    state_d = ST_WR_REL;
                end else if (ack_to) begin
                    state_d  = ST_DONE;
                    status_d = STAT_ACK_TO;
                end
            end
            ST_WR_REL: begin
                if (!ack_s) begin
                    state_d = ST_LOCK_WAIT;
                end else if (ack_to) begin
                    state_d  = ST_DONE;
                    status_d = STAT_ACK_TO;
                end
            end
            ST_LOCK_WAIT: begin
                // A stable lock in the final wait cycle still counts as success.
                if (lock_s && stab_cnt_q == STAB_LAST) begin
                    state_d  = ST_DONE;
                    status_d = STAT_OK;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d  = ST_DONE;
                    status_d = STAT_LOCK_TO;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Phase and wait counters restart on every state change and saturate at all-ones.
        ack_cnt_d  = (state_d != state_q) ? '0 : ack_cnt_q + AW'(ack_cnt_q != '1);
        wait_cnt_d = (state_d != state_q) ? '0 : wait_cnt_q + LW'(wait_cnt_q != '1);
        stab_cnt_d = (state_q == ST_LOCK_WAIT && lock_s) ? stab_cnt_q + SW'(stab_cnt_q != '1) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            status_q   <= STAT_OK;
            mult_q     <= '0;
            div_q      <= '0;
            rdata_q    <= '0;
            ack_cnt_q  <= '0;
            wait_cnt_q <= '0;
            stab_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            mult_q     <= mult_d;
            div_q      <= div_d;
            rdata_q    <= rdata_d;
            ack_cnt_q  <= ack_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    // A stale ack from an aborted handshake must drain before a new request starts.
    assign req_ready_o   = state_q == ST_IDLE && !ack_s;
    assign busy_o        = state_q != ST_IDLE;
    assign fll_req_o     = state_q == ST_RD_REQ || state_q == ST_WR_REQ;
    assign fll_wrn_o     = state_q != ST_WR_REQ;
    assign fll_addr_o    = fll_req_o ? FLL_CFG1_ADDR : 2'b00;
    assign fll_wdata_o   = state_q == ST_WR_REQ ? cfg1_merge(rdata_q, div_q, mult_q) : '0;
    assign done_valid_o  = state_q == ST_DONE;
    assign done_status_o = status_q;
    assign lock_o        = lock_s;

endmodule

// File: tb/tb_fll_reconfig_seq.sv
// tb_fll_reconfig_seq: randomized self-checking bench for fll_reconfig_seq against a behavioural FLL model.
module tb_fll_reconfig_seq;

    localparam int AT = 256;
    localparam int LT = 4096;
    localparam int LS = 16;
    localparam int E  = 13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_mult = '0;
    logic [3:0]  req_div = '0;
    logic        done_valid;
    logic [1:0]  done_status;
    logic        busy;
    logic        fll_req;
    logic        fll_wrn;
    logic [1:0]  fll_addr;
    logic [31:0] fll_wdata;
    logic        fll_ack;
    logic [31:0] fll_rdata = '0;
    logic        fll_lock = 1'b0;
    logic        lock_o;

    int   ack_mode = 0;
    logic ack_hold = 1'b0;

    // 0: loopback, otherwise ack is driven from ack_hold (1: stuck low, 2: latched high once requested)
    assign fll_ack = (ack_mode == 0) ? fll_req : ack_hold;

    always #5 clk = ~clk;

    fll_reconfig_seq dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_mult_i    (req_mult),
        .req_div_i     (req_div),
        .done_valid_o  (done_valid),
        .done_status_o (done_status),
        .busy_o        (busy),
        .fll_req_o     (fll_req),
        .fll_wrn_o     (fll_wrn),
        .fll_addr_o    (fll_addr),
        .fll_wdata_o   (fll_wdata),
        .fll_ack_i     (fll_ack),
        .fll_rdata_i   (fll_rdata),
        .fll_lock_i    (fll_lock),
        .lock_o        (lock_o)
    );

    int checks = 0;
    int failures = 0;

    bit lock_arr [0:4399];

    int          done_cyc, done_st, done_cnt, req_hi, lock_err, addr_err;
    logic        wr_seen;
    logic [31:0] wdata_seen;
    logic [1:0]  status_after;
    logic        busy_after, done_after;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // lock_arr[i] is the fll_lock_i level driven in scenario cycle i-4.
    task automatic fill_lock(input int kind, input int g);
        for (int i = 0; i < 4400; i++)
            lock_arr[i] = (kind == 0) ? 1'b1 :
                          (kind == 1) ? ((i / 8) % 2 == 0) :
                          (kind == 2) ? (i != g + 4) :
                                        ($urandom_range(0, 19) != 0);
    endtask

    // Success at the first cycle ending LS consecutive synchronized-high cycles inside the wait window,
    // otherwise failure LT cycles after entering the wait.
    task automatic lock_model(output int dc, output int st);
        dc = E + LT;
        st = 1;
        for (int t = E + LS - 1; t < E + LT; t++) begin
            bit all_hi;
            all_hi = 1'b1;
            for (int j = 0; j < LS; j++)
                if (!lock_arr[t - j + 2]) all_hi = 1'b0;
            if (all_hi) begin
                dc = t + 1;
                st = 0;
                break;
            end
        end
    endtask

    task automatic run(input int mode, input logic [15:0] m, input logic [3:0] d,
                       input logic [31:0] rd, input int budget, input int rst_at);
        done_cyc = -1; done_st = 0; done_cnt = 0; req_hi = 0; lock_err = 0; addr_err = 0;
        wr_seen = 1'b0; wdata_seen = '0; status_after = 2'b11; busy_after = 1'b1; done_after = 1'b1;
        ack_mode = mode; ack_hold = 1'b0; fll_rdata = rd; req_mult = m; req_div = d;
        for (int k = -4; k <= budget; k++) begin
            @(posedge clk);
            #1;
            fll_lock  = lock_arr[k + 4];
            req_valid = (k == 0);
            @(negedge clk);
            if (k == 0) check("ready_at_req", req_ready, 1);
            if (k == 1) check("busy_after_accept", busy, 1);
            if (fll_req) begin
                req_hi++;
                if (fll_addr !== 2'b01) addr_err++;
            end
            if (fll_req && !fll_wrn && !wr_seen) begin
                wr_seen = 1'b1;
                wdata_seen = fll_wdata;
            end
            if (mode == 2 && fll_req) ack_hold = 1'b1;
            if (rst_at < 0 && k >= -2 && lock_o !== lock_arr[k + 2]) lock_err++;
            if (done_valid) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    done_st = int'(done_status);
                end
            end
            if (k == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("reset_outputs",
                      {fll_req, fll_wrn, fll_addr, fll_wdata, done_valid, done_status, busy, lock_o},
                      {1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0});
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("ready_after_reset", req_ready, 1);
            end
            if (done_cyc >= 0 && k == done_cyc + 1) begin
                status_after = done_status;
                busy_after = busy;
                done_after = done_valid;
                break;
            end
        end
    endtask

    task automatic expect_loopback(input string tag, input logic [15:0] m, input logic [3:0] d,
                                   input logic [31:0] rd);
        int dc, st;
        lock_model(dc, st);
        check({tag, "_done_cyc"}, done_cyc, dc);
        check({tag, "_status"}, done_st, st);
        check({tag, "_status_held"}, status_after, st);
        check({tag, "_one_pulse"}, {done_cnt[7:0], done_after, busy_after}, {8'd1, 1'b0, 1'b0});
        check({tag, "_wdata"}, {wr_seen, wdata_seen},
              {1'b1, (rd & 32'hC3FF_0000) | (32'(d) << 26) | 32'(m)});
        check({tag, "_req_cycles"}, req_hi, 6);
        check({tag, "_port_lock"}, {addr_err, lock_err}, 0);
    endtask

    initial begin
        logic rb;
        logic [15:0] m;
        logic [3:0]  d;
        logic [31:0] rd;
        int kind;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_values",
              {fll_req, fll_wrn, fll_addr, fll_wdata, done_valid, done_status, busy, lock_o},
              {1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0});
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_init", req_ready, 1);

        fill_lock(0, 0);
        run(0, 16'h05F5, 4'h2, 32'hC0AB_0000, 80, -1);
        check("happy_wdata", wdata_seen, 32'hC8AB_05F5);
        check("happy_done_cyc", done_cyc, 29);
        expect_loopback("happy", 16'h05F5, 4'h2, 32'hC0AB_0000);

        fill_lock(2, 18);
        run(0, 16'h1234, 4'h7, 32'h5555_AAAA, 200, -1);
        expect_loopback("glitch", 16'h1234, 4'h7, 32'h5555_AAAA);

        fill_lock(1, 0);
        run(0, 16'hBEEF, 4'h9, 32'hFFFF_FFFF, 4300, -1);
        check("lock_to_cycle", done_cyc, E + LT);
        expect_loopback("toggle", 16'hBEEF, 4'h9, 32'hFFFF_FFFF);

        fill_lock(0, 0);
        run(0, 16'h00FF, 4'h3, 32'h0000_0000, 60, 9);
        check("reset_no_done", done_cnt, 0);
        run(0, 16'hA5A5, 4'hC, 32'h8123_4567, 80, -1);
        expect_loopback("post_reset", 16'hA5A5, 4'hC, 32'h8123_4567);

        run(1, 16'h1111, 4'h1, 32'h0, 400, -1);
        check("ack_never_done_cyc", done_cyc, 1 + AT);
        check("ack_never_status", {done_st[1:0], status_after}, {2'b10, 2'b10});
        check("ack_never_req_cycles", req_hi, AT);
        check("ack_never_no_write", wr_seen, 0);

        run(2, 16'h2222, 4'h2, 32'h0, 400, -1);
        check("stuck_ack_done_cyc", done_cyc, 4 + AT);
        check("stuck_ack_status", done_st, 2);
        check("stuck_ack_no_write", {wr_seen, req_hi[7:0]}, {1'b0, 8'd3});
        rb = 1'b0;
        repeat (5) begin
            @(negedge clk);
            rb |= req_ready;
        end
        check("stuck_ack_ready_blocked", rb, 0);
        @(posedge clk);
        #1 ack_hold = 1'b0;
        @(negedge clk);
        check("ready_c0", req_ready, 0);
        @(negedge clk);
        check("ready_c1", req_ready, 0);
        @(negedge clk);
        check("ready_c2", req_ready, 1);

        for (int i = 0; i < 8; i++) begin
            m = 16'($urandom);
            d = 4'($urandom);
            rd = $urandom;
            kind = $urandom_range(0, 2);
            fill_lock(kind == 1 ? 3 : kind, $urandom_range(11, 24));
            run(0, m, d, rd, 4300, -1);
            expect_loopback($sformatf("rand%0d", i), m, d, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
